// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: requester-side bus of the shared 1101 scan controller.
interface pattern_scan_ctrl_if #(
  parameter int NREQ = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W = $clog2(WORD_W + 1)
);
  logic [NREQ-1:0] req;
  logic [NREQ*WORD_W-1:0] data;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic done;
  logic [$clog2(NREQ)-1:0] done_id;
  logic [CNT_W-1:0] match_cnt;
  modport master(output req, data, input gnt, busy, done, done_id, match_cnt);
  modport slave(input req, data, output gnt, busy, done, done_id, match_cnt);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: round-robin sharing of one serial 1101 detector among NREQ requesters.
// Define SCAN_STATS_EN to add the total_matches / jobs_done statistics outputs.
module pattern_scan_ctrl #(
  parameter int NREQ = 4,
  parameter int WORD_W = 8,
  parameter int DET_LAT = 2,
  parameter int CNT_W = $clog2(WORD_W + 1)
) (
  input  logic clk,
  input  logic reset,
  pattern_scan_ctrl_if.slave bus,
  output logic det_a,
  output logic det_rst,
  input  logic det_out
`ifdef SCAN_STATS_EN
  ,
  output logic [15:0] total_matches,
  output logic [15:0] jobs_done
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WORD_W + DET_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;
  state_t state;
  logic [WORD_W-1:0] sr;
  logic [CW-1:0] cyc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IW-1:0] rr_ptr, cur, pick;
  logic prev;
  // lowest offset from rr_ptr wins because it is written last
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[(int'(rr_ptr) + i) % NREQ]) pick = IW'((int'(rr_ptr) + i) % NREQ);
  end
  assign cnt_nxt = cnt + CNT_W'(det_out && !prev);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      cyc <= '0;
      cnt <= '0;
      rr_ptr <= '0;
      cur <= '0;
      prev <= 1'b0;
      bus.gnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.done_id <= '0;
      bus.match_cnt <= '0;
      det_a <= 1'b0;
      det_rst <= 1'b1;
`ifdef SCAN_STATS_EN
      total_matches <= '0;
      jobs_done <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (|bus.req) begin
          state <= LOAD;
          cur <= pick;
          sr <= bus.data[pick*WORD_W +: WORD_W];
          bus.gnt <= NREQ'(1) << pick;
          bus.busy <= 1'b1;
          cnt <= '0;
          det_a <= 1'b0;
          det_rst <= 1'b1;
        end
        LOAD: begin
          state <= SHIFT;
          det_rst <= 1'b0;
          det_a <= sr[WORD_W-1];
          sr <= sr << 1;
          cyc <= '0;
          prev <= 1'b0;
        end
        SHIFT: begin
          cnt <= cnt_nxt;
          prev <= det_out;
          cyc <= cyc + 1'b1;
          det_a <= sr[WORD_W-1];
          sr <= sr << 1;
          if (cyc == CW'(WORD_W - 1)) begin
            state <= DRAIN;
            det_a <= 1'b0;
            cyc <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt_nxt;
          prev <= det_out;
          cyc <= cyc + 1'b1;
          if (cyc == CW'(DET_LAT - 1)) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.match_cnt <= cnt_nxt;
            bus.done_id <= cur;
`ifdef SCAN_STATS_EN
            total_matches <= (17'(total_matches) + 17'(cnt_nxt) > 17'hFFFF) ? 16'hFFFF : total_matches + 16'(cnt_nxt);
            jobs_done <= jobs_done + 16'd1;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          bus.gnt <= '0;
          bus.busy <= 1'b0;
          det_rst <= 1'b1;
          rr_ptr <= (int'(cur) == NREQ - 1) ? '0 : cur + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: random and directed jobs checked against a window-count / round-robin model.
// Build with SCAN_STATS_EN defined to also check the statistics outputs.
module tb_pattern_scan_ctrl;
  localparam int NREQ = 4;
  localparam int WORD_W = 8;
  localparam int DET_LAT = 2;
  localparam int GLEN = 2 + WORD_W + DET_LAT;
  logic clk = 1'b0;
  logic reset;
  logic det_a, det_rst, det_out;
  logic [3:0] hist;
  int n_chk = 0, n_pass = 0;
  int mptr = 0;
  int m_tot = 0, m_jobs = 0;
`ifdef SCAN_STATS_EN
  logic [15:0] total_matches, jobs_done;
`endif
  pattern_scan_ctrl_if #(.NREQ(NREQ), .WORD_W(WORD_W)) bus();
  pattern_scan_ctrl #(.NREQ(NREQ), .WORD_W(WORD_W), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .det_a(det_a), .det_rst(det_rst), .det_out(det_out)
`ifdef SCAN_STATS_EN
    , .total_matches(total_matches), .jobs_done(jobs_done)
`endif
  );
  always #5 clk = ~clk;
  // stand-in detector: registered Moore output, two cycles behind the last bit
  always_ff @(posedge clk) begin
    if (det_rst) begin
      hist <= '0;
      det_out <= 1'b0;
    end else begin
      hist <= {hist[2:0], det_a};
      det_out <= (hist == 4'b1101);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int ref_count(input logic [WORD_W-1:0] w);
    int n = 0;
    for (int p = WORD_W - 1; p >= 3; p--) if (w[p -: 4] == 4'b1101) n++;
    return n;
  endfunction
  function automatic int ref_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) if (r[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return 0;
  endfunction
  task automatic run_job(input logic [NREQ-1:0] r, input logic [31:0] d, input bit drop);
    int e, gap, glen, dpos, exp_cnt;
    logic [3:0] mc;
    logic [1:0] id;
    e = ref_pick(r);
    exp_cnt = ref_count(d[e*WORD_W +: WORD_W]);
    bus.req = r;
    bus.data = d;
    gap = 0;
    while (bus.gnt == '0 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("grant_latency", 32'(gap), 32'd1);
    check("gnt", 32'(bus.gnt), 32'(1) << e);
    check("busy", 32'(bus.busy), 32'd1);
    if (drop) begin
      bus.req = '0;
      bus.data = $urandom;
    end
    glen = 0;
    dpos = 0;
    mc = '0;
    id = '0;
    while (bus.gnt != '0 && glen < 40) begin
      glen++;
      if (bus.done) begin
        dpos = glen;
        mc = bus.match_cnt;
        id = bus.done_id;
      end
      @(negedge clk);
    end
    check("grant_len", 32'(glen), 32'(GLEN));
    check("done_pos", 32'(dpos), 32'(GLEN));
    check("match_cnt", 32'(mc), 32'(exp_cnt));
    check("done_id", 32'(id), 32'(e));
    check("held_cnt", 32'(bus.match_cnt), 32'(exp_cnt));
    mptr = (e + 1) % NREQ;
    m_tot = (m_tot + exp_cnt > 16'hFFFF) ? 16'hFFFF : m_tot + exp_cnt;
    m_jobs = (m_jobs + 1) % 65536;
  endtask
  task automatic check_stats();
`ifdef SCAN_STATS_EN
    check("total_matches", 32'(total_matches), 32'(m_tot));
    check("jobs_done", 32'(jobs_done), 32'(m_jobs));
`endif
  endtask
  initial begin
    int n;
    reset = 1'b0;
    bus.req = '0;
    bus.data = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    check("rst_id", 32'(bus.done_id), 32'd0);
    check("rst_det_rst", 32'(det_rst), 32'd1);
    check("rst_det_a", 32'(det_a), 32'd0);
    check_stats();
    reset = 1'b1;
    @(negedge clk);
    run_job(4'b0001, 32'h0000000D, 1'b0);
    run_job(4'b0001, 32'h000000DB, 1'b0);
    run_job(4'b0001, 32'h00000000, 1'b0);
    check_stats();
    run_job(4'b0001, 32'h000000FF, 1'b0);
    for (int k = 0; k < 5; k++) run_job(4'b1111, $urandom, 1'b0);
    run_job(4'b0010, $urandom, 1'b0);
    run_job(4'b0011, $urandom, 1'b0);
    run_job(4'b0011, $urandom, 1'b0);
    for (int k = 0; k < 30; k++)
      run_job(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3) == 0);
    check_stats();
    bus.req = 4'b0001;
    bus.data = 32'h000000DB;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_start", 32'(bus.gnt), 32'd1);
    repeat (5) @(negedge clk);
    bus.req = '0;
    reset = 1'b0;
    #1;
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_cnt", 32'(bus.match_cnt), 32'd0);
    check("abort_det_rst", 32'(det_rst), 32'd1);
    check("abort_det_a", 32'(det_a), 32'd0);
    mptr = 0;
    m_tot = 0;
    m_jobs = 0;
    check_stats();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job(4'b0100, $urandom, 1'b0);
    run_job(4'b0001, 32'h0000006D, 1'b0);
    check_stats();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Controller that shares one serial "1101" Moore sequence-detector datapath between NREQ requesters. It arbitrates round-robin among pending requests and loads the granted requester's parallel word. It clears the detector, shifts the word in MSB-first one bit per clock, counts detector match pulses, and returns the count with a done pulse. It sits between the processor-side request ports and the detector instance, which it drives through det_a/det_rst and observes through det_out.

## Interface
- NREQ, 4: number of requesters (2..8).
- WORD_W, 8: bits per scan word (4..32).
- DET_LAT, 2: cycles from last bit on det_a to its det_out pulse (detector's registered Moore output).
- CNT_W, $clog2(WORD_W+1): match counter width.

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- req  in  NREQ  per-requester request, level.
- data  in  NREQ*WORD_W  requester i word at [i*WORD_W +: WORD_W].
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse, result valid.
- done_id  out  $clog2(NREQ)  index of finished requester, held until next done.
- match_cnt  out  CNT_W  matches found in last word, held until next done.
- det_a  out  1  serial bit to detector.
- det_rst  out  1  synchronous active-high clear to detector.
- det_out  in  1  detector Moore output.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DRAIN, DONE.
- IDLE: if any req, pick the first set bit at or after rr_ptr (wrapping) → LOAD; latch data word into shift register, set gnt, zero counter.
- LOAD (1 cycle): det_rst=1, det_a=0 → SHIFT.
- SHIFT (WORD_W cycles): det_a = shift-reg MSB, shift left each cycle → DRAIN after last bit.
- DRAIN (DET_LAT cycles): det_a=0 → DONE.
- DONE (1 cycle): done=1, match_cnt/done_id updated, gnt cleared; rr_ptr ← granted index+1 mod NREQ → IDLE.
- Counting: during SHIFT and DRAIN, increment on each det_out rising edge (det_out=1 and previous det_out sample=0). Previous sample is forced 0 in LOAD. Overlapping patterns count (1101101 → 2).
- Counter width suffices: max matches floor((WORD_W-1)/3); no saturation needed.
- req dropped mid-scan: ignored; scan completes, done still issued.
- data changes after LOAD: ignored (word already latched).
- Reset values: gnt=0, busy=0, done=0, done_id=0, match_cnt=0, det_a=0, det_rst=1 (detector held clear), rr_ptr=0, state IDLE.
- Reset asserted mid-scan: abort immediately to reset values; no done is emitted for the aborted job.

## Timing
- req seen at edge t (IDLE) → gnt high from t+1 through the DONE cycle.
- Total grant length 2+WORD_W+DET_LAT cycles; done is in the last grant cycle.
- Back-to-back: the next grant appears at the earliest one cycle after DONE (IDLE cycle); throughput 1 word per WORD_W+DET_LAT+3 cycles.
- Simultaneous requests: strict round-robin, so no requester waits more than NREQ-1 jobs.

## Configuration
- SCAN_STATS_EN defined:
  - Adds output total_matches (16 bits), a saturating-at-0xFFFF sum of all match_cnt values, updated in DONE.
  - Adds output jobs_done (16 bits), wrapping.
  - Both are reset to 0.
- SCAN_STATS_EN undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- NREQ=4, WORD_W=8: req=0001, data0=0x0D → gnt=0001 for 12 cycles, done with match_cnt=1, done_id=0.
- data0=0xDB (11011011) → match_cnt=2; data0=0x00 and 0xFF → match_cnt=0.
- req=1111 held continuously → grants in order 0,1,2,3,0 with one IDLE cycle between jobs.
- rr_ptr=2, req=0011 → grant 0 next (wrap), then 1.
- reset low during SHIFT bit 4 → gnt/busy/done/match_cnt=0, det_rst=1 same cycle; after release, req=0100 runs clean from LOAD.
- With SCAN_STATS_EN: three jobs with 0x0D, 0xDB, 0x00 → total_matches=3, jobs_done=3.
